// File: rtl/reset.sv
// Power-up and request-driven reset generator: holds rst high for LENGTH clock
// edges after power-up or after rst_req is released. rst is always a flop output.
module reset #(
    parameter int LENGTH = 1
) (
    input  logic ck,
    input  logic rst_req,
    output logic rst
);

    localparam int CW = (LENGTH < 2) ? 1 : $clog2(LENGTH + 1);
    localparam logic [CW-1:0] LOAD = CW'(LENGTH);

    if (LENGTH < 1 || LENGTH > 65535) begin : g_bad_length
        $error("reset: LENGTH must be in 1..65535");
    end

    // No reset input exists, so power-up state comes from register initial values.
    logic [CW-1:0] cnt_q = LOAD;
    logic [CW-1:0] cnt_d;
    logic          rst_q = 1'b1;
    logic          rst_d;

    always_comb begin
        cnt_d = cnt_q;
        rst_d = 1'b0;
        if (rst_req) begin
            cnt_d = LOAD;
            rst_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            rst_d = (cnt_d != '0);
        end
    end

    always_ff @(posedge ck) begin
        cnt_q <= cnt_d;
        rst_q <= rst_d;
    end

    assign rst = rst_q;

endmodule

// File: tb/tb_reset.sv
// Bench for the reset generator: LENGTH=1, 4 and 17 side by side, checked each
// cycle against an edge-counting model plus hand-computed literal expectations.
module tb_reset;

    logic       ck = 1'b0;
    logic [2:0] req_v = 3'b000;
    logic       rst1, rst4, rst17;

    int total = 0;
    int bad = 0;

    reset #(.LENGTH(1))  u_l1  (.ck(ck), .rst_req(req_v[0]), .rst(rst1));
    reset #(.LENGTH(4))  u_l4  (.ck(ck), .rst_req(req_v[1]), .rst(rst4));
    reset #(.LENGTH(17)) u_l17 (.ck(ck), .rst_req(req_v[2]), .rst(rst17));

    always #5 ck = ~ck;

    // Model: rst after an edge is high while fewer than LENGTH consecutive
    // req-low edges have been seen since the last request (power-up counts as one).
    int lens[3] = '{1, 4, 17};
    int zeros[3] = '{0, 0, 0};

    always @(posedge ck) begin
        for (int i = 0; i < 3; i++) begin
            if (req_v[i]) zeros[i] = 0;
            else if (zeros[i] < 1000000) zeros[i] = zeros[i] + 1;
        end
    end

    function automatic logic model_rst(input int idx);
        return (zeros[idx] < lens[idx]) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Compare process: just before each rising edge (outputs settled).
    always @(negedge ck) begin
        chk("model_l1", rst1, model_rst(0));
        chk("model_l4", rst4, model_rst(1));
        chk("model_l17", rst17, model_rst(2));
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge ck);
    endtask

    int vec_req[8] = '{7, 0, 2, 0, 4, 0, 1, 0};
    int vec_n[8]   = '{2, 1, 1, 2, 1, 5, 3, 20};

    initial begin
        #1;
        chk("pwr_t0_l1", rst1, 1'b1);
        chk("pwr_t0_l4", rst4, 1'b1);
        chk("pwr_t0_l17", rst17, 1'b1);

        wait_edges(1);
        chk("pwr_e1_l1", rst1, 1'b0);
        chk("pwr_e1_l4", rst4, 1'b1);
        wait_edges(2);
        chk("pwr_e3_l4", rst4, 1'b1);
        wait_edges(1);
        chk("pwr_e4_l4", rst4, 1'b0);
        wait_edges(12);
        chk("pwr_e16_l17", rst17, 1'b1);
        wait_edges(1);
        chk("pwr_e17_l17", rst17, 1'b0);
        wait_edges(3);
        chk("idle_l17", rst17, 1'b0);
        chk("idle_l4", rst4, 1'b0);
        chk("idle_l1", rst1, 1'b0);

        // Long request on LENGTH=17, then release.
        req_v[2] = 1'b1;
        wait_edges(27);
        chk("hold27_l17", rst17, 1'b1);
        req_v[2] = 1'b0;
        wait_edges(16);
        chk("rel16_l17", rst17, 1'b1);
        wait_edges(1);
        chk("rel17_l17", rst17, 1'b0);

        // LENGTH=4: pulse, count down to cnt=2, pulse again to restart.
        req_v[1] = 1'b1;
        wait_edges(1);
        chk("pulse_a_l4", rst4, 1'b1);
        req_v[1] = 1'b0;
        wait_edges(2);
        chk("mid_l4", rst4, 1'b1);
        req_v[1] = 1'b1;
        wait_edges(1);
        req_v[1] = 1'b0;
        wait_edges(3);
        chk("restart3_l4", rst4, 1'b1);
        wait_edges(1);
        chk("restart4_l4", rst4, 1'b0);

        // LENGTH=1: single-cycle pulse gives a single-cycle reset.
        req_v[0] = 1'b1;
        wait_edges(1);
        chk("pulse_l1", rst1, 1'b1);
        req_v[0] = 1'b0;
        wait_edges(1);
        chk("release_l1", rst1, 1'b0);

        // Directed mixed-request vectors, checked by the model every cycle.
        for (int k = 0; k < 8; k++) begin
            req_v = 3'(vec_req[k]);
            wait_edges(vec_n[k]);
        end
        chk("final_l1", rst1, 1'b0);
        chk("final_l4", rst4, 1'b0);
        chk("final_l17", rst17, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
